mp_link_ctrl: RTL and testbench
===============================

MP_LINK_CTRL -- requirements
Module: mp_link_ctrl

Interface
REQ-001 SHALL have parameter BEACON_PERIOD, default 1000000, meaning the number of clk cycles between successive 'R' (8'h52) beacons while waiting for the peer (legal range 2..2^24).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port multiplayer, input, 1, level; the multiplayer mode is selected.
REQ-005 SHALL have port player_ready, input, 1, level; the local player is waiting to start.
REQ-006 SHALL have port game_over, input, 1, level; the local player has lost.
REQ-007 SHALL have port tx_full, input, 1; the UART TX FIFO is full.
REQ-008 SHALL have port rx_empty, input, 1; the UART RX FIFO is empty.
REQ-009 SHALL have port r_data, input, 8; the RX FIFO head byte, valid whenever rx_empty=0.
REQ-010 SHALL have port wr_uart, output, 1, one-cycle TX FIFO write strobe.
REQ-011 SHALL have port w_data, output, 8, registered TX byte, valid while wr_uart=1.
REQ-012 SHALL have port rd_uart, output, 1, one-cycle RX FIFO pop strobe.
REQ-013 SHALL have port start_game, output, 1, one-cycle pulse; both players are ready.
REQ-014 SHALL have port peer_lost, output, 1, level; the opponent lost, so the local player won.
REQ-015 SHALL have port link_state, output, 3; the current FSM state code.

Function
REQ-016 SHALL implement the FSM states IDLE=0, WAIT_PEER=1, SYNC=2, PLAYING=3, SEND_L=4, LOST=5, WON=6, with link_state equal to the registered state.
REQ-017 SHALL move from any state to IDLE on the next edge when multiplayer=0; any pending transmission is dropped and wr_uart is not asserted.
REQ-018 SHALL move IDLE -> WAIT_PEER when multiplayer=1 and player_ready=1.
REQ-019 SHALL run a beacon counter in WAIT_PEER: loaded 0 on entry; at 0 with tx_full=0, issue wr_uart with w_data=8'h52 and reload BEACON_PERIOD-1; otherwise decrement; at 0 with tx_full=1, hold at 0 and retry each cycle.
REQ-020 SHALL assert rd_uart for exactly one cycle whenever rx_empty=0, in every state, so at most one byte is consumed per cycle; a byte is acted on only in the cycle rd_uart pops it.
REQ-021 SHALL move WAIT_PEER -> SYNC when a popped byte equals 8'h52; any other byte is discarded.
REQ-022 SHALL return WAIT_PEER -> IDLE if player_ready falls before a peer 'R' is popped.
REQ-023 SHALL send exactly one 'R' acknowledge in SYNC (wr_uart=1, w_data=8'h52 on the first cycle with tx_full=0), then move to PLAYING and pulse start_game in the same cycle as that write.
REQ-024 SHALL, in PLAYING, discard popped 'R' bytes and other non-'L' bytes.
REQ-025 SHALL move PLAYING -> WON when a popped byte equals 8'h4C; peer_lost=1 while in WON.
REQ-026 SHALL move PLAYING -> SEND_L when game_over=1 and no 'L' is popped in that cycle.
REQ-027 SHALL give a popped 'L' priority when game_over=1 and an 'L' is popped in the same cycle: go to WON and send nothing.
REQ-028 SHALL, in SEND_L, write 8'h4C exactly once on the first cycle with tx_full=0, then move to LOST.
REQ-029 SHALL leave LOST and WON only by multiplayer=0 (-> IDLE), or by game_over=0 and player_ready=1 (-> WAIT_PEER, counter reloaded 0).
REQ-030 SHALL keep wr_uart=0 in IDLE, PLAYING, LOST and WON, and never assert wr_uart while tx_full=1.

Reset
REQ-031 SHALL, on rst=1, set state=IDLE, beacon counter=0, wr_uart=0, w_data=8'h00, rd_uart=0, start_game=0, peer_lost=0 immediately and independently of clk.
REQ-032 SHALL abandon any handshake on reset asserted mid-operation; after release the block starts in IDLE and issues no write until REQ-018 is met.

Verification (BEACON_PERIOD=16)
REQ-033 SHALL have a beacon test: multiplayer=1 and player_ready=1, rx_empty=1 -> 'R' writes at 2, 18, 34 cycles after the ready edge; link_state=1.
REQ-034 SHALL have a handshake test: in WAIT_PEER, present 8'h52 on RX -> rd_uart for 1 cycle, next state SYNC, one 8'h52 write, start_game pulse in the same cycle, link_state=3.
REQ-035 SHALL have a local-loss test: in PLAYING, game_over=1 with tx_full=1 for 5 cycles -> no write during those cycles, one 8'h4C write when tx_full falls, link_state=5.
REQ-036 SHALL have a collision test: in PLAYING, game_over rises in the same cycle 8'h4C is popped -> link_state=6, peer_lost=1, no 'L' written.
REQ-037 SHALL have a noise test: in WAIT_PEER, feed 8'h41 then 8'h52 -> 8'h41 is popped and ignored, 8'h52 moves the FSM to SYNC.
REQ-038 SHALL have an abort test: multiplayer falls in SYNC with tx_full=1 -> IDLE next cycle, no write ever; rst pulsed in WON -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mp_link_ctrl_if.sv
// UART FIFO side of the multiplayer link: the controller is the master,
// the UART wrapper is the slave.
interface mp_link_ctrl_if;
    logic       tx_full;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       rd_uart;

    modport master (
        input  tx_full, rx_empty, r_data,
        output wr_uart, w_data, rd_uart
    );

    modport slave (
        output tx_full, rx_empty, r_data,
        input  wr_uart, w_data, rd_uart
    );
endinterface

// File: rtl/mp_link_ctrl.sv
// Two-player link controller: beacons 'R' until the peer answers, starts the game,
// then exchanges the single 'L' (lost) byte that decides the winner.
module mp_link_ctrl #(
    parameter int unsigned BEACON_PERIOD = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  multiplayer,
    input  logic                  player_ready,
    input  logic                  game_over,
    mp_link_ctrl_if.master        uart,
    output logic                  start_game,
    output logic                  peer_lost,
    output logic [2:0]            link_state
);
    localparam logic [7:0]  BYTE_R = 8'h52;
    localparam logic [7:0]  BYTE_L = 8'h4C;
    localparam logic [23:0] RELOAD = 24'(BEACON_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_PEER = 3'd1,
        SYNC      = 3'd2,
        PLAYING   = 3'd3,
        SEND_L    = 3'd4,
        LOST      = 3'd5,
        WON       = 3'd6
    } state_t;

    state_t      r_state,      w_state_nxt;
    logic [23:0] r_beacon_cnt, w_beacon_cnt_nxt;
    logic        r_wr_uart,    w_wr_uart_nxt;
    logic [7:0]  r_w_data,     w_w_data_nxt;
    logic        r_start_game, w_start_game_nxt;
    logic        w_pop;
    logic        w_got_r;
    logic        w_got_l;

    // Every non-empty cycle pops exactly one byte; the byte is decoded in that same cycle.
    assign w_pop   = ~uart.rx_empty & ~rst;
    assign w_got_r = w_pop & (uart.r_data == BYTE_R);
    assign w_got_l = w_pop & (uart.r_data == BYTE_L);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch can be inferred.
        w_state_nxt      = r_state;
        w_beacon_cnt_nxt = r_beacon_cnt;
        w_wr_uart_nxt    = 1'b0;
        w_w_data_nxt     = r_w_data;
        w_start_game_nxt = 1'b0;

        if (!multiplayer) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (player_ready) begin
                        w_state_nxt      = WAIT_PEER;
                        w_beacon_cnt_nxt = '0;
                    end
                end
                WAIT_PEER: begin
                    // A beacon is only sent while staying here, so SYNC owns the single ack.
                    if (w_got_r) begin
                        w_state_nxt = SYNC;
                    end else if (!player_ready) begin
                        w_state_nxt = IDLE;
                    end else if (r_beacon_cnt != '0) begin
                        w_beacon_cnt_nxt = r_beacon_cnt - 24'd1;
                    end else if (!uart.tx_full) begin
                        w_wr_uart_nxt    = 1'b1;
                        w_w_data_nxt     = BYTE_R;
                        w_beacon_cnt_nxt = RELOAD;
                    end
                end
                SYNC: begin
                    if (!uart.tx_full) begin
                        w_wr_uart_nxt    = 1'b1;
                        w_w_data_nxt     = BYTE_R;
                        w_start_game_nxt = 1'b1;
                        w_state_nxt      = PLAYING;
                    end
                end
                PLAYING: begin
                    // A received 'L' wins over a simultaneous local loss.
                    if (w_got_l) begin
                        w_state_nxt = WON;
                    end else if (game_over) begin
                        w_state_nxt = SEND_L;
                    end
                end
                SEND_L: begin
                    if (!uart.tx_full) begin
                        w_wr_uart_nxt = 1'b1;
                        w_w_data_nxt  = BYTE_L;
                        w_state_nxt   = LOST;
                    end
                end
                LOST, WON: begin
                    if (!game_over && player_ready) begin
                        w_state_nxt      = WAIT_PEER;
                        w_beacon_cnt_nxt = '0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: registers update with non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_beacon_cnt <= '0;
            r_wr_uart    <= 1'b0;
            r_w_data     <= 8'h00;
            r_start_game <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_beacon_cnt <= w_beacon_cnt_nxt;
            r_wr_uart    <= w_wr_uart_nxt;
            r_w_data     <= w_w_data_nxt;
            r_start_game <= w_start_game_nxt;
        end
    end

    assign uart.wr_uart = r_wr_uart;
    assign uart.w_data  = r_w_data;
    assign uart.rd_uart = w_pop;
    assign start_game   = r_start_game;
    assign peer_lost    = (r_state == WON);
    assign link_state   = r_state;

endmodule

// File: tb/tb_mp_link_ctrl.sv
// Directed scenarios plus random traffic for mp_link_ctrl, compared every cycle
// against a transaction-level model of the link protocol.
module tb_mp_link_ctrl;
    localparam int BP = 16;
    localparam int S_IDLE = 0, S_WAIT = 1, S_SYNC = 2, S_PLAY = 3;
    localparam int S_SENDL = 4, S_LOST = 5, S_WON = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       multiplayer;
    logic       player_ready;
    logic       game_over;
    logic       start_game;
    logic       peer_lost;
    logic [2:0] link_state;

    mp_link_ctrl_if u_if();

    mp_link_ctrl #(.BEACON_PERIOD(BP)) dut (
        .clk          (clk),
        .rst          (rst),
        .multiplayer  (multiplayer),
        .player_ready (player_ready),
        .game_over    (game_over),
        .uart         (u_if),
        .start_game   (start_game),
        .peer_lost    (peer_lost),
        .link_state   (link_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: protocol phase, pending TX byte, and the absolute cycle
    // at which the next beacon becomes due.
    int         m_state;
    bit         m_wr;
    bit         m_start;
    logic [7:0] m_wd;
    longint     m_due;
    longint     cyc = 0;
    logic [7:0] rxq[$];

    task automatic model_reset();
        m_state = S_IDLE;
        m_wr    = 1'b0;
        m_start = 1'b0;
        m_wd    = 8'h00;
        m_due   = 0;
    endtask

    task automatic enter_wait();
        m_state = S_WAIT;
        m_due   = cyc + 1;
    endtask

    task automatic model_step(input bit pop, input logic [7:0] b);
        bit got_r, got_l;
        got_r   = pop && (b == 8'h52);
        got_l   = pop && (b == 8'h4C);
        m_wr    = 1'b0;
        m_start = 1'b0;
        if (!multiplayer) begin
            m_state = S_IDLE;
        end else if (m_state == S_IDLE) begin
            if (player_ready) enter_wait();
        end else if (m_state == S_WAIT) begin
            if (got_r) m_state = S_SYNC;
            else if (!player_ready) m_state = S_IDLE;
            else if (cyc >= m_due && !u_if.tx_full) begin
                m_wr  = 1'b1;
                m_wd  = 8'h52;
                m_due = cyc + BP;
            end
        end else if (m_state == S_SYNC) begin
            if (!u_if.tx_full) begin
                m_wr = 1'b1; m_wd = 8'h52; m_start = 1'b1; m_state = S_PLAY;
            end
        end else if (m_state == S_PLAY) begin
            if (got_l) m_state = S_WON;
            else if (game_over) m_state = S_SENDL;
        end else if (m_state == S_SENDL) begin
            if (!u_if.tx_full) begin
                m_wr = 1'b1; m_wd = 8'h4C; m_state = S_LOST;
            end
        end else begin
            if (!game_over && player_ready) enter_wait();
        end
    endtask

    // One clock: present RX head, check the pop strobe mid-cycle, step the
    // model at the edge and compare the registered outputs just after it.
    task automatic cycle();
        bit         pop;
        logic [7:0] b;
        u_if.rx_empty = (rxq.size() == 0);
        u_if.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
        @(negedge clk);
        check("rd_uart", u_if.rd_uart, !rst && rxq.size() != 0);
        pop = !rst && rxq.size() != 0;
        b   = u_if.r_data;
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else model_step(pop, b);
        if (pop) void'(rxq.pop_front());
        #1;
        check("link_state", link_state, m_state);
        check("wr_uart", u_if.wr_uart, m_wr);
        check("w_data", u_if.w_data, m_wd);
        check("start_game", start_game, m_start);
        check("peer_lost", peer_lost, m_state == S_WON);
    endtask

    initial begin
        int         sel;
        logic [7:0] nb;

        rst = 1'b1; multiplayer = 1'b0; player_ready = 1'b0; game_over = 1'b0;
        u_if.tx_full = 1'b0; u_if.rx_empty = 1'b1; u_if.r_data = 8'h00;
        model_reset();
        #1;
        check("rst_state", link_state, 0);
        check("rst_wr", u_if.wr_uart, 0);
        check("rst_wdata", u_if.w_data, 8'h00);
        check("rst_start", start_game, 0);
        check("rst_lost", peer_lost, 0);
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle();

        // Beacon: writes land at edges 2, 18, 34 after the ready edge.
        multiplayer = 1'b1; player_ready = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            cycle();
            check("beacon_at", u_if.wr_uart, (k == 1) || (k == 17) || (k == 33));
        end
        check("beacon_state", link_state, S_WAIT);

        // Handshake
        rxq.push_back(8'h52);
        cycle();
        check("hs_sync", link_state, S_SYNC);
        cycle();
        check("hs_wr", u_if.wr_uart, 1);
        check("hs_data", u_if.w_data, 8'h52);
        check("hs_start", start_game, 1);
        check("hs_play", link_state, S_PLAY);

        // Local loss with a full TX FIFO
        game_over = 1'b1; u_if.tx_full = 1'b1;
        cycle();
        check("loss_sendl", link_state, S_SENDL);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("loss_blocked", u_if.wr_uart, 0);
        end
        u_if.tx_full = 1'b0;
        cycle();
        check("loss_wr", u_if.wr_uart, 1);
        check("loss_data", u_if.w_data, 8'h4C);
        check("loss_state", link_state, S_LOST);
        cycle();

        // Rematch, then collision of local loss with a received 'L'
        game_over = 1'b0;
        cycle();
        check("rematch_wait", link_state, S_WAIT);
        rxq.push_back(8'h52);
        cycle(); cycle();
        check("rematch_play", link_state, S_PLAY);
        rxq.push_back(8'h4C); game_over = 1'b1;
        cycle();
        check("coll_state", link_state, S_WON);
        check("coll_lost", peer_lost, 1);
        check("coll_nowr", u_if.wr_uart, 0);
        cycle();

        // Asynchronous reset while in WON, with a byte waiting in RX
        rxq.push_back(8'h41); u_if.rx_empty = 1'b0; u_if.r_data = 8'h41;
        #2 rst = 1'b1;
        #1;
        check("arst_state", link_state, 0);
        check("arst_lost", peer_lost, 0);
        check("arst_wr", u_if.wr_uart, 0);
        check("arst_wdata", u_if.w_data, 8'h00);
        check("arst_rd", u_if.rd_uart, 0);
        model_reset();
        cycle();
        rst = 1'b0; rxq.delete(); game_over = 1'b0;

        // Noise before the peer's 'R', then abort in SYNC with TX blocked
        cycle();
        check("noise_wait", link_state, S_WAIT);
        rxq.push_back(8'h41); rxq.push_back(8'h52); u_if.tx_full = 1'b1;
        cycle();
        check("noise_ignored", link_state, S_WAIT);
        cycle();
        check("noise_sync", link_state, S_SYNC);
        multiplayer = 1'b0;
        cycle();
        check("abort_idle", link_state, S_IDLE);
        u_if.tx_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("abort_nowr", u_if.wr_uart, 0);
        end

        // Random traffic
        for (int k = 0; k < 4000; k++) begin
            rst          = ($urandom_range(0, 999) < 3);
            multiplayer  = ($urandom_range(0, 99) < 98);
            player_ready = ($urandom_range(0, 99) < 90);
            game_over    = ($urandom_range(0, 99) < 15);
            u_if.tx_full = ($urandom_range(0, 99) < 30);
            if (rxq.size() < 4 && $urandom_range(0, 99) < 25) begin
                sel = $urandom_range(0, 9);
                nb  = 8'($urandom);
                if (sel < 4) nb = 8'h52;
                else if (sel < 7) nb = 8'h4C;
                else if (sel < 8) nb = 8'h41;
                rxq.push_back(nb);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
